e_mdu_ext: RTL and testbench
============================

E_MDU_EXT -- requirements
Module: e_mdu_ext

Interface
REQ-001 Parameter W, default 32, operand/HI/LO width; legal values 8..64.
REQ-002 Parameter MUL_LAT, default 5, busy cycles for multiply and multiply-accumulate ops; legal values >=1.
REQ-003 Parameter DIV_LAT, default 10, busy cycles for divide ops; legal values >=1.
REQ-004 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_srcA  in  W  operand A (dividend / MTHI-MTLO source).
REQ-007 i_srcB  in  W  operand B (divisor).
REQ-008 i_mduOp  in  5  op code: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU; 13..31 treated as NONE.
REQ-009 i_start  in  1  launch of ops 1-4 and 9-12; ignored for other codes.
REQ-010 i_cancel  in  1  abort of the in-flight op (exception flush).
REQ-011 or_hi  out  W  architectural HI register.
REQ-012 or_lo  out  W  architectural LO register.
REQ-013 or_result  out  W  combinational read: or_hi for MFHI, or_lo for MFLO, else 0.
REQ-014 or_busy  out  1  high while an op is in flight.
REQ-015 or_done  out  1  one-cycle pulse when an op commits to HI/LO.

Function
REQ-016 States IDLE and RUN with down-counter cnt; IDLE iff cnt==0; or_busy SHALL equal (state==RUN) as a register.
REQ-017 Launch: edge with IDLE, i_start=1, valid launch op, i_cancel=0 -> RUN, cnt=MUL_LAT (ops 1,2,9-12) or DIV_LAT (ops 3,4); result computed into temp HI/LO at that edge from current operands and current HI/LO.
REQ-018 In RUN, each edge decrements cnt; on the edge where cnt==1: HI/LO <= temp, state IDLE, or_busy 0, or_done 1 for exactly the following cycle.
REQ-019 Net latency: or_busy high for exactly LAT cycles; HI/LO visible LAT cycles after launch edge.
REQ-020 i_start while RUN SHALL be ignored (no relaunch, no operand capture); upstream stalls on or_busy.
REQ-021 MTHI/MTLO write i_srcA to HI/LO only in IDLE and only when no launch occurs that edge; ignored in RUN.
REQ-022 i_cancel=1 in RUN: next edge forces IDLE, cnt=0, or_busy 0, no or_done, HI/LO unchanged; i_cancel in IDLE blocks any launch/MTHI/MTLO that edge.
REQ-023 MULT/MULTU: {HI,LO} = signed/unsigned 2W-bit product.
REQ-024 MADD/MADDU: {HI,LO} = {HI,LO} + signed/unsigned product, mod 2^(2W); MSUB/MSUBU subtract likewise.
REQ-025 DIV/DIVU: LO = quotient truncated toward zero, HI = remainder with sign of dividend.
REQ-026 Divide by zero (both forms): LO = all ones, HI = i_srcA; busy for DIV_LAT as normal.
REQ-027 Signed overflow DIV (A = most-negative, B = -1): LO = A, HI = 0.
REQ-028 HI/LO SHALL not change in RUN except at commit (REQ-018).

Reset
REQ-029 i_reset=1 SHALL immediately (no clock needed) set or_hi=0, or_lo=0, or_busy=0, or_done=0, cnt=0, temp HI/LO=0, state IDLE.
REQ-030 Reset mid-operation SHALL discard the op; no commit or or_done after release.
REQ-031 First launch SHALL be accepted on the first rising edge with i_reset low.

Verification
REQ-032 W=32, MUL_LAT=5: MULT A=0xFFFFFFFE B=3 -> busy 5 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFFA, done pulse 1 cycle.
REQ-033 DIV A=-7 B=2 (DIV_LAT=10) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles; DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
REQ-034 MTHI 0, MTLO 0xFFFFFFFF, MADDU A=1 B=1 -> HI=1, LO=0; then MSUB A=1 B=1 -> HI=0, LO=0xFFFFFFFF.
REQ-035 MULT launched, i_start+MTHI asserted during busy, i_cancel at cycle 3 -> busy drops next edge, HI/LO hold pre-launch values, no done.
REQ-036 Async reset asserted between edges in RUN -> outputs 0 immediately; after release MFLO returns 0, no done pulse.

Source files
------------

// File: rtl/e_mdu_ext.sv
// Multi-cycle multiply/divide unit with HI/LO registers, MADD/MSUB accumulate and flush support.
// Results are computed at launch and held in temp registers until the latency counter expires.
module e_mdu_ext #(
  parameter int unsigned W       = 32,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [W-1:0] i_srcA,
  input  logic [W-1:0] i_srcB,
  input  logic [4:0]   i_mduOp,
  input  logic         i_start,
  input  logic         i_cancel,
  output logic [W-1:0] or_hi,
  output logic [W-1:0] or_lo,
  output logic [W-1:0] or_result,
  output logic         or_busy,
  output logic         or_done
);

  localparam logic [4:0] OpNone  = 5'd0;
  localparam logic [4:0] OpMult  = 5'd1;
  localparam logic [4:0] OpMultu = 5'd2;
  localparam logic [4:0] OpDiv   = 5'd3;
  localparam logic [4:0] OpDivu  = 5'd4;
  localparam logic [4:0] OpMfhi  = 5'd5;
  localparam logic [4:0] OpMflo  = 5'd6;
  localparam logic [4:0] OpMthi  = 5'd7;
  localparam logic [4:0] OpMtlo  = 5'd8;
  localparam logic [4:0] OpMadd  = 5'd9;
  localparam logic [4:0] OpMaddu = 5'd10;
  localparam logic [4:0] OpMsub  = 5'd11;
  localparam logic [4:0] OpMsubu = 5'd12;

  localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic [W-1:0]    tmp_hi_q, tmp_hi_d;
  logic [W-1:0]    tmp_lo_q, tmp_lo_d;
  logic            done_q, done_d;

  logic            is_mul, is_div, is_signed, launch, commit;
  logic [2*W-1:0]  a_ext, b_ext, prod, acc, mul_res;
  logic            a_neg, b_neg, b_zero;
  logic [W-1:0]    a_mag, b_mag, b_div, q_mag, r_mag;
  logic [W-1:0]    div_q, div_r;

  // Op decode
  always_comb begin
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    case (i_mduOp)
      OpMult:  begin is_mul = 1'b1; is_signed = 1'b1; end
      OpMultu: is_mul = 1'b1;
      OpMadd:  begin is_mul = 1'b1; is_signed = 1'b1; end
      OpMaddu: is_mul = 1'b1;
      OpMsub:  begin is_mul = 1'b1; is_signed = 1'b1; end
      OpMsubu: is_mul = 1'b1;
      OpDiv:   begin is_div = 1'b1; is_signed = 1'b1; end
      OpDivu:  is_div = 1'b1;
      default: ;
    endcase
  end

  assign launch = (state_q == StIdle) && i_start && (is_mul || is_div) && !i_cancel;
  assign commit = (state_q == StRun) && !i_cancel && (cnt_q == CntW'(1));

  // Multiply datapath: sign/zero extend to 2W so the truncated product is exact mod 2^(2W)
  always_comb begin
    a_ext = is_signed ? {{W{i_srcA[W-1]}}, i_srcA} : {{W{1'b0}}, i_srcA};
    b_ext = is_signed ? {{W{i_srcB[W-1]}}, i_srcB} : {{W{1'b0}}, i_srcB};
    prod  = a_ext * b_ext;
    acc   = {hi_q, lo_q};
    case (i_mduOp)
      OpMadd, OpMaddu: mul_res = acc + prod;
      OpMsub, OpMsubu: mul_res = acc - prod;
      default:         mul_res = prod;
    endcase
  end

  // Divide datapath on magnitudes; the most-negative / -1 case wraps back to A with remainder 0
  always_comb begin
    b_zero = (i_srcB == '0);
    a_neg  = is_signed && i_srcA[W-1];
    b_neg  = is_signed && i_srcB[W-1];
    a_mag  = a_neg ? -i_srcA : i_srcA;
    b_mag  = b_neg ? -i_srcB : i_srcB;
    b_div  = b_zero ? W'(1) : b_mag;
    q_mag  = a_mag / b_div;
    r_mag  = a_mag % b_div;
    if (b_zero) begin
      div_q = '1;
      div_r = i_srcA;
    end else begin
      div_q = (a_neg ^ b_neg) ? -q_mag : q_mag;
      div_r = a_neg ? -r_mag : r_mag;
    end
  end

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      tmp_hi_q <= '0;
      tmp_lo_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (launch) begin
          state_d = StRun;
          if (is_div) begin
            cnt_d    = CntW'(DIV_LAT);
            tmp_hi_d = div_r;
            tmp_lo_d = div_q;
          end else begin
            cnt_d    = CntW'(MUL_LAT);
            tmp_hi_d = mul_res[2*W-1:W];
            tmp_lo_d = mul_res[W-1:0];
          end
        end else if (!i_cancel) begin
          if (i_mduOp == OpMthi) hi_d = i_srcA;
          if (i_mduOp == OpMtlo) lo_d = i_srcA;
        end
      end
      StRun: begin
        if (i_cancel) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (commit) begin
          state_d = StIdle;
          cnt_d   = '0;
          hi_d    = tmp_hi_q;
          lo_d    = tmp_lo_q;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    or_hi   = hi_q;
    or_lo   = lo_q;
    or_busy = (state_q == StRun);
    or_done = done_q;
    case (i_mduOp)
      OpMfhi:  or_result = hi_q;
      OpMflo:  or_result = lo_q;
      OpNone:  or_result = '0;
      default: or_result = '0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu_ext.sv
// Directed plus randomized bench for e_mdu_ext; HI/LO expectations come from an arithmetic model.
module tb_e_mdu_ext;

  localparam int unsigned W       = 32;
  localparam int unsigned MUL_LAT = 5;
  localparam int unsigned DIV_LAT = 10;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic [W-1:0]  i_srcA, i_srcB;
  logic [4:0]    i_mduOp;
  logic          i_start, i_cancel;
  logic [W-1:0]  or_hi, or_lo, or_result;
  logic          or_busy, or_done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] m_hi, m_lo;

  e_mdu_ext #(.W(W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_srcA    (i_srcA),
    .i_srcB    (i_srcB),
    .i_mduOp   (i_mduOp),
    .i_start   (i_start),
    .i_cancel  (i_cancel),
    .or_hi     (or_hi),
    .or_lo     (or_lo),
    .or_result (or_result),
    .or_busy   (or_busy),
    .or_done   (or_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  // Reference: {HI,LO} after an op, from plain 64-bit arithmetic
  function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] acc, ua, ub;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    acc = {hi, lo};
    case (op)
      5'd1:  return 64'(sa * sb);
      5'd2:  return ua * ub;
      5'd9:  return acc + 64'(sa * sb);
      5'd10: return acc + ua * ub;
      5'd11: return acc - 64'(sa * sb);
      5'd12: return acc - ua * ub;
      5'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      5'd4: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return acc;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [63:0] exp;
    int lat, busy_cnt;
    lat = (op == 5'd3 || op == 5'd4) ? DIV_LAT : MUL_LAT;
    exp = model(op, a, b, m_hi, m_lo);
    i_mduOp = op;
    i_srcA  = a;
    i_srcB  = b;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_mduOp = 5'd0;
    busy_cnt = 0;
    for (int i = 0; i < lat + 4 && or_busy; i++) begin
      if (i == 0) check({tag, "_hold"}, {or_hi, or_lo}, {m_hi, m_lo});
      busy_cnt++;
      tick();
    end
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(lat));
    check({tag, "_done"}, 64'(or_done), 64'd1);
    {m_hi, m_lo} = exp;
    check({tag, "_hilo"}, {or_hi, or_lo}, {m_hi, m_lo});
    tick();
    check({tag, "_done_pulse"}, 64'(or_done), 64'd0);
  endtask

  task automatic do_mt(input string tag, input logic [4:0] op, input logic [31:0] a);
    i_mduOp = op;
    i_srcA  = a;
    i_start = 1'($urandom_range(1));
    tick();
    i_start = 1'b0;
    i_mduOp = 5'd0;
    if (op == 5'd7) m_hi = a;
    else            m_lo = a;
    check(tag, {or_hi, or_lo}, {m_hi, m_lo});
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corner [6];
    corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
    if ($urandom_range(2) == 0) return corner[$urandom_range(5)];
    return $urandom;
  endfunction

  initial begin
    logic [4:0]  ops [10];
    logic [4:0]  op;
    logic        saw_done;
    logic [63:0] pre;
    ops = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12};
    i_reset  = 1'b1;
    i_srcA   = '0;
    i_srcB   = '0;
    i_mduOp  = 5'd0;
    i_start  = 1'b0;
    i_cancel = 1'b0;
    m_hi     = '0;
    m_lo     = '0;
    #1;
    check("reset_outputs", {or_hi, or_lo}, 64'd0);
    check("reset_busy_done", {62'd0, or_busy, or_done}, 64'd0);
    @(negedge i_clk);
    i_reset = 1'b0;

    // First edge after reset release must accept the launch
    run_op("mult_dir", 5'd1, 32'hFFFF_FFFE, 32'd3);
    check("mult_dir_const", {or_hi, or_lo}, 64'hFFFF_FFFF_FFFF_FFFA);

    run_op("div_dir", 5'd3, 32'hFFFF_FFF9, 32'd2);
    check("div_dir_const", {or_hi, or_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_zero", 5'd4, 32'd7, 32'd0);
    check("divu_zero_const", {or_hi, or_lo}, 64'h0000_0007_FFFF_FFFF);
    run_op("div_ovf", 5'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_const", {or_hi, or_lo}, 64'h0000_0000_8000_0000);

    do_mt("mthi0", 5'd7, 32'h0);
    do_mt("mtlo1s", 5'd8, 32'hFFFF_FFFF);
    run_op("maddu_dir", 5'd10, 32'd1, 32'd1);
    check("maddu_dir_const", {or_hi, or_lo}, 64'h0000_0001_0000_0000);
    run_op("msub_dir", 5'd11, 32'd1, 32'd1);
    check("msub_dir_const", {or_hi, or_lo}, 64'h0000_0000_FFFF_FFFF);

    i_mduOp = 5'd5;
    #1 check("mfhi", 64'(or_result), 64'(m_hi));
    i_mduOp = 5'd6;
    #1 check("mflo", 64'(or_result), 64'(m_lo));
    i_mduOp = 5'd0;
    @(negedge i_clk);

    // Cancel during a multiply, with start+MTHI noise while busy
    pre = {m_hi, m_lo};
    i_mduOp = 5'd1;
    i_srcA  = 32'd12345;
    i_srcB  = 32'd678;
    i_start = 1'b1;
    tick();
    i_mduOp = 5'd7;
    i_srcA  = 32'hDEAD_BEEF;
    tick();
    check("cancel_busy_mid", {63'd0, or_busy}, 64'd1);
    check("cancel_hold_mid", {or_hi, or_lo}, pre);
    tick();
    i_cancel = 1'b1;
    tick();
    i_cancel = 1'b0;
    i_start  = 1'b0;
    i_mduOp  = 5'd0;
    check("cancel_busy_drop", {63'd0, or_busy}, 64'd0);
    saw_done = or_done;
    for (int i = 0; i < MUL_LAT + 2; i++) begin
      tick();
      saw_done |= or_done;
    end
    check("cancel_no_done", {63'd0, saw_done}, 64'd0);
    check("cancel_hilo", {or_hi, or_lo}, pre);

    // Cancel in IDLE blocks MTHI and launch
    i_cancel = 1'b1;
    i_mduOp  = 5'd7;
    i_srcA   = 32'h1234_5678;
    tick();
    check("idle_cancel_mthi", {or_hi, or_lo}, pre);
    i_mduOp = 5'd1;
    i_start = 1'b1;
    tick();
    check("idle_cancel_launch", {63'd0, or_busy}, 64'd0);
    i_cancel = 1'b0;

    // Undefined op codes never launch
    i_mduOp = 5'd13;
    tick();
    check("op13_no_launch", {63'd0, or_busy}, 64'd0);
    i_mduOp = 5'd31;
    tick();
    check("op31_no_launch", {31'd0, or_busy, or_hi}, {32'd0, pre[63:32]});
    i_start = 1'b0;
    i_mduOp = 5'd0;

    // Asynchronous reset mid-run
    i_mduOp = 5'd2;
    i_srcA  = 32'hFFFF_0000;
    i_srcB  = 32'h0001_0003;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_mduOp = 5'd0;
    tick();
    #2 i_reset = 1'b1;
    #1;
    check("async_rst_hilo", {or_hi, or_lo}, 64'd0);
    check("async_rst_flags", {62'd0, or_busy, or_done}, 64'd0);
    #1 i_reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    saw_done = 1'b0;
    for (int i = 0; i < MUL_LAT + 3; i++) begin
      tick();
      saw_done |= or_done | or_busy;
    end
    check("rst_no_done", {63'd0, saw_done}, 64'd0);
    i_mduOp = 5'd6;
    #1 check("rst_mflo", 64'(or_result), 64'd0);
    i_mduOp = 5'd0;
    @(negedge i_clk);

    // Randomized ops against the model
    for (int n = 0; n < 30; n++) begin
      op = ops[$urandom_range(9)];
      if (op == 5'd7 || op == 5'd8) do_mt("rnd_mt", op, pick_operand());
      else                          run_op("rnd_op", op, pick_operand(), pick_operand());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
